tetris_move_sched: RTL



---
 rtl/tetris_pkg.sv | 46 ++++
 rtl/tetris_btn_edge.sv | 21 ++
 rtl/tetris_move_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and helpers for the falling-piece move scheduler.
// Op codes double as indices into the pending-flag vector.
package tetris_pkg;

  localparam int OP_NUM = 5;

  typedef enum logic [2:0] {
    LEFT      = 3'd0,
    RIGHT     = 3'd1,
    ROT       = 3'd2,
    DOWN      = 3'd3,
    HARD_DOWN = 3'd4
  } move_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } sched_state_t;

  // Fixed priority: ROT > LEFT > RIGHT > HARD_DOWN > DOWN.
  function automatic move_op_t sel_op(input logic [OP_NUM-1:0] pend);
    move_op_t op;
    op = DOWN;
    if (pend[4]) op = HARD_DOWN;
    if (pend[1]) op = RIGHT;
    if (pend[0]) op = LEFT;
    if (pend[2]) op = ROT;
    return op;
  endfunction

  // HARD_DOWN also retires a pending gravity step; it is absorbed into y+2.
  function automatic logic [OP_NUM-1:0] clear_mask(input move_op_t op);
    logic [OP_NUM-1:0] m;
    case (op)
      LEFT:      m = 5'b00001;
      RIGHT:     m = 5'b00010;
      ROT:       m = 5'b00100;
      DOWN:      m = 5'b01000;
      HARD_DOWN: m = 5'b11000;
      default:   m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tetris_btn_edge.sv
// Four-lane rising-edge detector. History always tracks the buttons;
// only the reported edges are gated by the enable.
module tetris_btn_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] btn_i,
  output logic [3:0] rise_o
);

  logic [3:0] btn_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q & {4{en_i}};

endmodule

// File: rtl/tetris_move_sched.sv
// Turns button edges and a gravity timer into single move commands,
// offered one at a time over a valid/ready handshake.
module tetris_move_sched
  import tetris_pkg::*;
#(
  parameter int unsigned GRAV_DIV = 8,
  parameter int unsigned COOL     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_rot,
  input  logic              btn_drop,
  output logic              cmd_valid,
  output logic [2:0]        cmd_op,
  input  logic              cmd_ready,
  output logic              tick,
  output logic [OP_NUM-1:0] pend,
  output logic              overrun
);

  localparam int unsigned    CW        = $clog2(GRAV_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(GRAV_DIV - 1);
  localparam logic [7:0]     COOL_LOAD = (COOL > 0) ? 8'(COOL - 1) : 8'd0;

  sched_state_t      state_q, state_d;
  move_op_t          op_q, op_d;
  logic [OP_NUM-1:0] pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        cool_q, cool_d;
  logic [OP_NUM-1:0] clr;
  logic [OP_NUM-1:0] set_v;
  logic [OP_NUM-1:0] btn_set;
  logic [3:0]        rise;

  tetris_btn_edge u_btn_edge (
    .clk    (clk),
    .rst    (rst),
    .en_i   (enable),
    .btn_i  ({btn_drop, btn_rot, btn_right, btn_left}),
    .rise_o (rise)
  );

  assign tick = enable && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
  end

  // Gravity never counts as a lost request; a repeat simply merges.
  assign btn_set = {rise[3], 1'b0, rise[2:0]};
  assign set_v   = {rise[3], tick, rise[2:0]};

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cool_d  = cool_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (enable && (pend_q != '0)) begin
          op_d    = sel_op(pend_q);
          clr     = clear_mask(op_d);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          if (COOL > 0) begin
            state_d = COOLDOWN;
            cool_d  = COOL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      COOLDOWN: begin
        if (cool_q == 8'd0) state_d = IDLE;
        else                cool_d  = cool_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A set arriving with an issue-clear wins and is not an overrun.
  assign pend_d    = (pend_q & ~clr) | set_v;
  assign overrun_d = overrun_q | (|(btn_set & pend_q & ~clr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= LEFT;
      pend_q    <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
      cool_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
      cool_q    <= cool_d;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_op    = op_q;
  assign pend      = pend_q;
  assign overrun   = overrun_q;

endmodule
